vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the VGA pipeline. It drives the `pos_h`, `pos_v` and `blank` signals consumed by the disc renderer and other pixel-domain blocks. It also drives the `hsync`/`vsync` pins of the VGA connector. It runs entirely on the pixel clock and starts scanning only once the clock wizard reports `locked`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, sync active level (0 = active-low)

Ports:
- `pix_clk`  in  1  pixel clock; the only clock
- `rst`  in  1  asynchronous, active-high reset
- `locked`  in  1  clock wizard lock; scanning is enabled only while high
- `pos_h`  out  10  horizontal counter, range 0..H_TOTAL-1
- `pos_v`  out  10  vertical counter, range 0..V_TOTAL-1
- `blank`  out  1  high outside the active area
- `hsync`  out  1  horizontal sync at `SYNC_POL` level while active
- `vsync`  out  1  vertical sync at `SYNC_POL` level while active
- `line_start`  out  1  one-cycle pulse when `pos_h`==0
- `frame_start`  out  1  one-cycle pulse when `pos_h`==0 and `pos_v`==0
- `frame_cnt`  out  16  number of completed frames since scanning started

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; this is an elaboration-time assertion.
- FSM states: `IDLE`, `RUN`.
- **IDLE:** all outputs hold their reset values. On an edge with `locked`=1, the block enters `RUN` and loads the following:
  - `pos_h`=0, `pos_v`=0, `blank`=0
  - `line_start`=1, `frame_start`=1, `frame_cnt`=0
- **RUN, `locked`=1:** on each edge, `pos_h` increments.
  - At H_TOTAL-1, `pos_h` wraps to 0 and `pos_v` increments.
  - At V_TOTAL-1 with `pos_h`=H_TOTAL-1, both wrap to 0 and `frame_cnt` increments (modulo 2^16, so 65535→0).
- **RUN, `locked`=0:** the next edge returns the block to `IDLE` with reset output values. Resumption always restarts at (0,0) with `frame_cnt`=0.
- All outputs are registered and are decoded from the next counter value, so every output is aligned with `pos_h`/`pos_v` in the same cycle. Outputs are never decoded combinationally from the current count.
- Decode rules, using the next counter values:
  - `blank` = (h ≥ H_ACTIVE) or (v ≥ V_ACTIVE).
  - `hsync` is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656, 752).
  - `vsync` is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) = [490, 492), across whole lines (all h).
  - `line_start` = (h==0). `frame_start` = (h==0 && v==0).
- Reset values:
  - `pos_h`=0, `pos_v`=0, `blank`=1
  - `hsync` and `vsync` = ~`SYNC_POL` (inactive)
  - `line_start`=0, `frame_start`=0, `frame_cnt`=0, state `IDLE`
- Reset asserted mid-frame forces the reset values immediately, without waiting for a clock edge. After `rst` is released, the block behaves exactly as from power-up.

## Timing
- Latency from `locked` rising to the first pixel is 1 edge. The first `RUN` cycle shows pixel (0,0) with `blank`=0.
- Line period is exactly H_TOTAL cycles. Frame period is exactly H_TOTAL×V_TOTAL cycles (420000).
- `line_start` pulses once every 800 cycles. `frame_start` pulses once every 420000 cycles and coincides with a `line_start`.
- The sync pulse widths are exactly H_SYNC cycles and V_SYNC×H_TOTAL cycles, with no glitches at the boundaries.
- `blank` falls on the same cycle that `pos_h` becomes 0 on an active line. It rises on the cycle that `pos_h`=640.
- `frame_cnt` changes on the same cycle as `frame_start` (except the first frame, which shows 0).
- Downstream consumers sample `pos_h`/`pos_v`/`blank` on `pix_clk` with zero skew between them.

## Test plan
- **Reset and idle:** assert `rst` with `locked`=0 → outputs (0, 0, `blank`=1, `hsync`=1, `vsync`=1); they hold for 100 cycles while `locked`=0.
- **Start:** raise `locked` → on the next edge, `pos_h`=0, `pos_v`=0, `blank`=0, `frame_start`=1. On the following edge, `pos_h`=1 and `frame_start`=0.
- **Line timing:** over one line → `blank` is high for `pos_h` 640..799; `hsync` is low for exactly 96 cycles starting at `pos_h`=656; `line_start` is high only at `pos_h`=0; the wrap is 799→0 with `pos_v` 0→1.
- **Frame timing:** run 2 full frames → `vsync` is low for 1600 cycles starting at (0,490); the wrap is (799,524)→(0,0); `frame_cnt` goes 0→1→2; `frame_start` pulses are 420000 cycles apart.
- **Lock loss mid-frame:** drop `locked` at (300,200) → the next edge returns to `IDLE` reset values. Re-raising `locked` restarts at (0,0) with `frame_cnt`=0.
- **Async reset:** pulse `rst` between clock edges at (700,490) → outputs go to reset values before the next edge. The scan restarts at (0,0) one edge after `rst` falls with `locked`=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counts pixels/lines on the pixel clock and
// registers every raster output from the next counter value so all outputs
// stay cycle-aligned with pos_h/pos_v.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic        pix_clk,
   input  logic        rst,
   input  logic        locked,
   output logic [9:0]  pos_h,
   output logic [9:0]  pos_v,
   output logic        blank,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int unsigned CW       = 10;
   localparam int unsigned FW       = 16;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   // Counters are 10 bits wide, so neither total may exceed 1024
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
   end

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_pos_h;
   logic [CW-1:0]   r_pos_v;
   logic            r_blank;
   logic            r_hsync;
   logic            r_vsync;
   logic            r_line_start;
   logic            r_frame_start;
   logic [FW-1:0]   r_frame_cnt;

   state_t          w_state_nxt;
   logic            w_run;
   logic [CW-1:0]   w_h_nxt;
   logic [CW-1:0]   w_v_nxt;
   logic [FW-1:0]   w_fc_nxt;
   logic            w_blank_nxt;
   logic            w_hsync_nxt;
   logic            w_vsync_nxt;
   logic            w_line_start_nxt;
   logic            w_frame_start_nxt;

   // Next state, next counters and the outputs decoded from those counters
   always_comb begin
      w_state_nxt       = r_state;
      w_run             = 1'b0;
      w_h_nxt           = '0;
      w_v_nxt           = '0;
      w_fc_nxt          = '0;
      w_blank_nxt       = 1'b1;
      w_hsync_nxt       = ~SYNC_POL;
      w_vsync_nxt       = ~SYNC_POL;
      w_line_start_nxt  = 1'b0;
      w_frame_start_nxt = 1'b0;

      case (r_state)
         IDLE: begin
            if (locked) begin
               w_state_nxt = RUN;
               w_run       = 1'b1;
            end
         end
         RUN: begin
            if (locked) begin
               w_run    = 1'b1;
               w_fc_nxt = r_frame_cnt;
               if (r_pos_h == CW'(H_TOTAL - 1)) begin
                  if (r_pos_v == CW'(V_TOTAL - 1)) begin
                     w_fc_nxt = r_frame_cnt + FW'(1);
                  end else begin
                     w_v_nxt = r_pos_v + CW'(1);
                  end
               end else begin
                  w_h_nxt = r_pos_h + CW'(1);
                  w_v_nxt = r_pos_v;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_run) begin
         w_blank_nxt       = (w_h_nxt >= CW'(H_ACTIVE)) || (w_v_nxt >= CW'(V_ACTIVE));
         w_hsync_nxt       = ((w_h_nxt >= CW'(HS_START)) && (w_h_nxt < CW'(HS_END)))
                             ? SYNC_POL : ~SYNC_POL;
         w_vsync_nxt       = ((w_v_nxt >= CW'(VS_START)) && (w_v_nxt < CW'(VS_END)))
                             ? SYNC_POL : ~SYNC_POL;
         w_line_start_nxt  = (w_h_nxt == '0);
         w_frame_start_nxt = (w_h_nxt == '0) && (w_v_nxt == '0);
      end
   end

   // State and output registers; reset forces the idle values immediately
   always_ff @(posedge pix_clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_pos_h       <= '0;
         r_pos_v       <= '0;
         r_blank       <= 1'b1;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pos_h       <= w_h_nxt;
         r_pos_v       <= w_v_nxt;
         r_blank       <= w_blank_nxt;
         r_hsync       <= w_hsync_nxt;
         r_vsync       <= w_vsync_nxt;
         r_line_start  <= w_line_start_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_frame_cnt   <= w_fc_nxt;
      end
   end

   assign pos_h       = r_pos_h;
   assign pos_v       = r_pos_v;
   assign blank       = r_blank;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance for line timing and a
// shrunken-geometry instance for frame, lock-loss and reset behaviour, both
// checked against a time-since-start raster model.
module tb_vga_timing_gen;

   localparam bit          POL  = 1'b0;
   localparam int unsigned D_HA = 640, D_HFP = 16, D_HS = 96, D_HBP = 48;
   localparam int unsigned D_VA = 480, D_VFP = 10, D_VS = 2,  D_VBP = 33;
   localparam int unsigned D_HT = D_HA + D_HFP + D_HS + D_HBP;
   localparam int unsigned S_HA = 16,  S_HFP = 2,  S_HS = 4,  S_HBP = 3;
   localparam int unsigned S_VA = 6,   S_VFP = 1,  S_VS = 2,  S_VBP = 2;
   localparam int unsigned S_HT = S_HA + S_HFP + S_HS + S_HBP;
   localparam int unsigned S_VT = S_VA + S_VFP + S_VS + S_VBP;
   localparam int unsigned S_FT = S_HT * S_VT;

   typedef struct packed {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        blank;
      logic        hs;
      logic        vs;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   localparam obs_t RST_VAL = {10'd0, 10'd0, 1'b1, ~POL, ~POL, 1'b0, 1'b0, 16'd0};

   logic pix_clk = 1'b0;
   logic rst;
   logic locked_d;
   logic locked_s;

   logic [9:0]  pos_h_d, pos_v_d, pos_h_s, pos_v_s;
   logic        blank_d, hsync_d, vsync_d, ls_d, fs_d;
   logic        blank_s, hsync_s, vsync_s, ls_s, fs_s;
   logic [15:0] fc_d, fc_s;
   obs_t        obs_d, obs_s;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 pix_clk = ~pix_clk;

   vga_timing_gen u_dut_d (
      .pix_clk(pix_clk), .rst(rst), .locked(locked_d),
      .pos_h(pos_h_d), .pos_v(pos_v_d), .blank(blank_d),
      .hsync(hsync_d), .vsync(vsync_d), .line_start(ls_d),
      .frame_start(fs_d), .frame_cnt(fc_d)
   );

   vga_timing_gen #(
      .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
      .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
      .SYNC_POL(POL)
   ) u_dut_s (
      .pix_clk(pix_clk), .rst(rst), .locked(locked_s),
      .pos_h(pos_h_s), .pos_v(pos_v_s), .blank(blank_s),
      .hsync(hsync_s), .vsync(vsync_s), .line_start(ls_s),
      .frame_start(fs_s), .frame_cnt(fc_s)
   );

   assign obs_d = {pos_h_d, pos_v_d, blank_d, hsync_d, vsync_d, ls_d, fs_d, fc_d};
   assign obs_s = {pos_h_s, pos_v_s, blank_s, hsync_s, vsync_s, ls_s, fs_s, fc_s};

   // Reference model: whether scanning and how many edges since it began
   bit     run_d = 1'b0, run_s = 1'b0;
   longint t_d = 0, t_s = 0;

   always @(posedge pix_clk or posedge rst) begin
      if (rst) begin
         run_d <= 1'b0; t_d <= 0;
         run_s <= 1'b0; t_s <= 0;
      end else begin
         if (!locked_d)   run_d <= 1'b0;
         else if (run_d)  t_d <= t_d + 1;
         else begin run_d <= 1'b1; t_d <= 0; end
         if (!locked_s)   run_s <= 1'b0;
         else if (run_s)  t_s <= t_s + 1;
         else begin run_s <= 1'b1; t_s <= 0; end
      end
   end

   function automatic obs_t model_out(input bit run, input longint t,
                                      input int unsigned ha, hfp, hsw, hbp,
                                      input int unsigned va, vfp, vsw, vbp);
      obs_t   o;
      longint ht, vt, hh, vv;
      o = RST_VAL;
      if (run) begin
         ht = longint'(ha + hfp + hsw + hbp);
         vt = longint'(va + vfp + vsw + vbp);
         hh = t % ht;
         vv = (t / ht) % vt;
         o.h     = 10'(hh);
         o.v     = 10'(vv);
         o.blank = (hh >= longint'(ha)) || (vv >= longint'(va));
         o.hs    = (hh >= longint'(ha + hfp) && hh < longint'(ha + hfp + hsw)) ? POL : ~POL;
         o.vs    = (vv >= longint'(va + vfp) && vv < longint'(va + vfp + vsw)) ? POL : ~POL;
         o.ls    = (hh == 0);
         o.fs    = (hh == 0) && (vv == 0);
         o.fc    = 16'(t / (ht * vt));
      end
      return o;
   endfunction

   function automatic obs_t exp_d();
      return model_out(run_d, t_d, D_HA, D_HFP, D_HS, D_HBP, D_VA, D_VFP, D_VS, D_VBP);
   endfunction

   function automatic obs_t exp_s();
      return model_out(run_s, t_s, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP);
   endfunction

   task automatic step();
      @(posedge pix_clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; locked_d = 1'b0; locked_s = 1'b0;
      repeat (3) @(posedge pix_clk);
      #1;
      n_assert++;
      if (obs_d !== RST_VAL) begin
         n_fail++; $display("FAIL reset_d got=%h exp=%h", obs_d, RST_VAL);
      end
      n_assert++;
      if (obs_s !== RST_VAL) begin
         n_fail++; $display("FAIL reset_s got=%h exp=%h", obs_s, RST_VAL);
      end
      #3 rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         n_assert++;
         if (obs_d !== RST_VAL || obs_s !== RST_VAL) begin
            n_fail++;
            $display("FAIL idle_hold cyc=%0d got_d=%h got_s=%h exp=%h", i, obs_d, obs_s, RST_VAL);
         end
      end
   endtask

   task automatic test_start();
      locked_d = 1'b1;
      step();
      n_assert++;
      if (pos_h_d !== 10'd0 || pos_v_d !== 10'd0 || blank_d !== 1'b0 ||
          fs_d !== 1'b1 || ls_d !== 1'b1 || fc_d !== 16'd0) begin
         n_fail++; $display("FAIL start_first got=%h exp h=0 v=0 blank=0 ls=1 fs=1 fc=0", obs_d);
      end
      step();
      n_assert++;
      if (pos_h_d !== 10'd1 || pos_v_d !== 10'd0 || fs_d !== 1'b0 || ls_d !== 1'b0) begin
         n_fail++; $display("FAIL start_second got=%h exp h=1 v=0 ls=0 fs=0", obs_d);
      end
   endtask

   task automatic test_line_timing();
      int hs_cnt = 0, hs_first = -1, blank_cnt = 0, ls_cnt = 0, wraps = 0, guard = 0;
      logic [9:0] ph, pv;
      obs_t e;
      ph = pos_h_d; pv = pos_v_d;
      while (t_d < 2 * longint'(D_HT) && guard < 5000) begin
         step(); guard++;
         e = exp_d();
         n_assert++;
         if (obs_d !== e) begin
            n_fail++; $display("FAIL line_d t=%0d got=%h exp=%h", t_d, obs_d, e);
         end
         if (pos_v_d == 10'd1) begin
            if (hsync_d == POL) begin
               if (hs_first < 0) hs_first = int'(pos_h_d);
               hs_cnt++;
            end
            if (blank_d) blank_cnt++;
         end
         if (ls_d) ls_cnt++;
         if (ph == 10'(D_HT - 1) && pos_h_d == 10'd0 && pos_v_d == pv + 10'd1) wraps++;
         ph = pos_h_d; pv = pos_v_d;
      end
      n_assert++;
      if (guard >= 5000) begin n_fail++; $display("FAIL line_timeout got=%0d exp<5000", guard); end
      n_assert++;
      if (hs_cnt != int'(D_HS) || hs_first != int'(D_HA + D_HFP)) begin
         n_fail++; $display("FAIL hsync_window got=%0d@%0d exp=%0d@%0d", hs_cnt, hs_first, D_HS, D_HA + D_HFP);
      end
      n_assert++;
      if (blank_cnt != int'(D_HT - D_HA)) begin
         n_fail++; $display("FAIL hblank_len got=%0d exp=%0d", blank_cnt, D_HT - D_HA);
      end
      n_assert++;
      if (ls_cnt != 2 || wraps != 2) begin
         n_fail++; $display("FAIL line_wrap got ls=%0d wraps=%0d exp 2 2", ls_cnt, wraps);
      end
      locked_d = 1'b0;
      step();
      n_assert++;
      if (obs_d !== RST_VAL) begin
         n_fail++; $display("FAIL line_stop got=%h exp=%h", obs_d, RST_VAL);
      end
   endtask

   task automatic test_frame_timing();
      longint fs_t[$];
      int vs_cnt = 0, vs_h = -1, vs_v = -1, wraps = 0, guard = 0;
      logic [9:0] ph, pv;
      obs_t e;
      locked_s = 1'b1;
      step();
      if (fs_s) fs_t.push_back(t_s);
      if (vsync_s == POL) vs_cnt++;
      ph = pos_h_s; pv = pos_v_s;
      while (t_s < 2 * longint'(S_FT) + 3 && guard < 2000) begin
         step(); guard++;
         e = exp_s();
         n_assert++;
         if (obs_s !== e) begin
            n_fail++; $display("FAIL frame_s t=%0d got=%h exp=%h", t_s, obs_s, e);
         end
         if (fs_s) fs_t.push_back(t_s);
         if (t_s < longint'(S_FT) && vsync_s == POL) begin
            if (vs_h < 0) begin vs_h = int'(pos_h_s); vs_v = int'(pos_v_s); end
            vs_cnt++;
         end
         if (ph == 10'(S_HT - 1) && pv == 10'(S_VT - 1) && pos_h_s == 10'd0 && pos_v_s == 10'd0) wraps++;
         ph = pos_h_s; pv = pos_v_s;
      end
      n_assert++;
      if (vs_cnt != int'(S_VS * S_HT) || vs_h != 0 || vs_v != int'(S_VA + S_VFP)) begin
         n_fail++;
         $display("FAIL vsync_window got=%0d@(%0d,%0d) exp=%0d@(0,%0d)", vs_cnt, vs_h, vs_v, S_VS * S_HT, S_VA + S_VFP);
      end
      n_assert++;
      if (fs_t.size() != 3 || wraps != 2) begin
         n_fail++; $display("FAIL frame_pulses got fs=%0d wraps=%0d exp 3 2", fs_t.size(), wraps);
      end else begin
         n_assert++;
         if (fs_t[1] - fs_t[0] != longint'(S_FT) || fs_t[2] - fs_t[1] != longint'(S_FT)) begin
            n_fail++; $display("FAIL frame_period got=%0d,%0d exp=%0d", fs_t[1] - fs_t[0], fs_t[2] - fs_t[1], S_FT);
         end
      end
      n_assert++;
      if (fc_s !== 16'd2) begin
         n_fail++; $display("FAIL frame_cnt got=%0d exp=2", fc_s);
      end
   endtask

   task automatic advance_s(input longint k, input string tag);
      obs_t e;
      for (longint i = 0; i < k; i++) begin
         step();
         e = exp_s();
         n_assert++;
         if (obs_s !== e) begin
            n_fail++; $display("FAIL %s t=%0d got=%h exp=%h", tag, t_s, obs_s, e);
         end
      end
   endtask

   task automatic test_lock_loss();
      int th, tv, idle;
      longint k;
      for (int it = 0; it < 4; it++) begin
         th = (it == 0) ? 10 : int'($urandom_range(S_HT - 1, 0));
         tv = (it == 0) ? 4  : int'($urandom_range(S_VT - 1, 0));
         k  = (longint'(tv) * S_HT + th - (t_s % S_FT) + S_FT) % S_FT;
         advance_s(k, "lock_run");
         n_assert++;
         if (pos_h_s !== 10'(th) || pos_v_s !== 10'(tv)) begin
            n_fail++; $display("FAIL lock_pos got=(%0d,%0d) exp=(%0d,%0d)", pos_h_s, pos_v_s, th, tv);
         end
         locked_s = 1'b0;
         step();
         n_assert++;
         if (obs_s !== RST_VAL) begin
            n_fail++; $display("FAIL lock_drop got=%h exp=%h", obs_s, RST_VAL);
         end
         idle = int'($urandom_range(20, 1));
         advance_s(longint'(idle), "lock_idle");
         locked_s = 1'b1;
         step();
         n_assert++;
         if (pos_h_s !== 10'd0 || pos_v_s !== 10'd0 || fc_s !== 16'd0 || fs_s !== 1'b1 || blank_s !== 1'b0) begin
            n_fail++; $display("FAIL lock_resume got=%h exp h=0 v=0 fc=0 fs=1 blank=0", obs_s);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int it = 0; it < 4; it++) begin
         advance_s(longint'($urandom_range(S_FT + 50, 30)), "arst_run");
         #2 rst = 1'b1;
         #1;
         n_assert++;
         if (obs_s !== RST_VAL || obs_d !== RST_VAL) begin
            n_fail++; $display("FAIL async_rst got_s=%h got_d=%h exp=%h", obs_s, obs_d, RST_VAL);
         end
         #2 rst = 1'b0;
         step();
         n_assert++;
         if (pos_h_s !== 10'd0 || pos_v_s !== 10'd0 || fc_s !== 16'd0 || fs_s !== 1'b1) begin
            n_fail++; $display("FAIL arst_resume got=%h exp h=0 v=0 fc=0 fs=1", obs_s);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t e;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(39, 0) == 0) locked_s = ~locked_s;
         step();
         e = exp_s();
         n_assert++;
         if (obs_s !== e) begin
            n_fail++; $display("FAIL b2b_s t=%0d run=%0d got=%h exp=%h", t_s, run_s, obs_s, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_line_timing();
      test_frame_timing();
      test_lock_loss();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
